// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared constants, decoder phase decode and saturation bound helper
// for the LDPC variable-node datapath.
`default_nettype none

package ldpc_pkg;

  localparam int FSM_IDLE  = 0;
  localparam int FSM_LOAD  = 1;
  localparam int FSM_ITER  = 2;
  localparam int FSM_DEC   = 3;
  localparam int FSM_W     = 4;

  localparam int DEF_D_WID = 8;
  localparam int DEF_A_WID = 10;

  typedef enum logic [2:0] {
    PH_NONE = 3'd0,
    PH_IDLE = 3'd1,
    PH_LOAD = 3'd2,
    PH_ITER = 3'd3,
    PH_DEC  = 3'd4
  } phase_e;

  // Only one phase bit is honoured; load wins, then iterate, decide, idle.
  function automatic phase_e fsm_phase(input logic [FSM_W-1:0] fsm);
    if (fsm[FSM_LOAD])      return PH_LOAD;
    else if (fsm[FSM_ITER]) return PH_ITER;
    else if (fsm[FSM_DEC])  return PH_DEC;
    else if (fsm[FSM_IDLE]) return PH_IDLE;
    else                    return PH_NONE;
  endfunction

  // Largest magnitude of a symmetric w-bit two's-complement range.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ldpc_sat.sv
// ldpc_sat: symmetric saturator from IN_W to OUT_W bits; never emits the most
// negative OUT_W code.
`default_nettype none

module ldpc_sat
  import ldpc_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] val_o
);

  localparam logic signed [IN_W-1:0] LIM_P = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] LIM_N = -LIM_P;

  always_comb begin
    if (val_i > LIM_P) begin
      val_o = LIM_P[OUT_W-1:0];
    end else if (val_i < LIM_N) begin
      val_o = LIM_N[OUT_W-1:0];
    end else begin
      val_o = val_i[OUT_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ldpc_vn_cell.sv
// ldpc_vn_cell: layered-decoder variable node holding the posterior and the
// last c2v message per edge; serves extrinsic reads and tracks hard decisions.
`default_nettype none

module ldpc_vn_cell
  import ldpc_pkg::*;
#(
  parameter int D_WID  = DEF_D_WID,
  parameter int A_WID  = DEF_A_WID,
  parameter int N_EDGE = 3,
  parameter int E_WID  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [FSM_W-1:0] fsm,
  input  logic             sin,
  input  logic [D_WID-1:0] din,
  input  logic             c2v_vld,
  input  logic [E_WID-1:0] c2v_idx,
  input  logic [D_WID-1:0] c2v_msg,
  input  logic             v2c_req,
  input  logic [E_WID-1:0] v2c_idx,
  output logic             v2c_vld,
  output logic [D_WID-1:0] v2c_msg,
  output logic             hd,
  output logic             hd_chg,
  output logic [A_WID-1:0] post
);

  localparam int S_WID = A_WID + 1;
  localparam logic [E_WID:0] N_EDGE_C = (E_WID + 1)'(N_EDGE);

  logic signed [A_WID-1:0] post_q, post_d;
  logic signed [D_WID-1:0] old_q [N_EDGE];
  logic signed [D_WID-1:0] old_d [N_EDGE];
  logic                    v2c_vld_q, v2c_vld_d;
  logic        [D_WID-1:0] v2c_msg_q, v2c_msg_d;
  logic                    hd_chg_q, hd_chg_d;

  phase_e                  phase;
  logic                    c2v_hit;
  logic                    do_upd;
  logic signed [D_WID-1:0] c2v_old;
  logic signed [D_WID-1:0] v2c_old;
  logic signed [S_WID-1:0] upd_sum;
  logic signed [S_WID-1:0] ext_sum;
  logic signed [A_WID-1:0] post_sat;
  logic signed [D_WID-1:0] ext_sat;

  assign phase   = fsm_phase(fsm);
  assign c2v_hit = {1'b0, c2v_idx} < N_EDGE_C;
  assign do_upd  = (phase == PH_ITER) && c2v_vld && c2v_hit;

  // Out-of-range indices select no edge, so the old message reads as zero.
  always_comb begin
    c2v_old = '0;
    v2c_old = '0;
    for (int e = 0; e < N_EDGE; e++) begin
      if (c2v_idx == E_WID'(e)) c2v_old = old_q[e];
      if (v2c_idx == E_WID'(e)) v2c_old = old_q[e];
    end
  end

  assign upd_sum = S_WID'(post_q) - S_WID'(c2v_old) + S_WID'($signed(c2v_msg));
  assign ext_sum = S_WID'(post_q) - S_WID'(v2c_old);

  ldpc_sat #(.IN_W(S_WID), .OUT_W(A_WID)) u_sat_post (
    .val_i (upd_sum),
    .val_o (post_sat)
  );

  ldpc_sat #(.IN_W(S_WID), .OUT_W(D_WID)) u_sat_ext (
    .val_i (ext_sum),
    .val_o (ext_sat)
  );

  always_comb begin
    post_d    = post_q;
    old_d     = old_q;
    hd_chg_d  = hd_chg_q;
    v2c_vld_d = 1'b0;
    v2c_msg_d = v2c_msg_q;
    case (phase)
      PH_LOAD: begin
        if (sin) begin
          post_d   = A_WID'($signed(din));
          old_d    = '{default: '0};
          hd_chg_d = 1'b0;
        end
      end
      PH_ITER: begin
        if (do_upd) begin
          post_d = post_sat;
          for (int e = 0; e < N_EDGE; e++) begin
            if (c2v_idx == E_WID'(e)) old_d[e] = $signed(c2v_msg);
          end
          if (post_sat[A_WID-1] != post_q[A_WID-1]) hd_chg_d = 1'b1;
        end
        if (v2c_req) begin
          v2c_vld_d = 1'b1;
          v2c_msg_d = ext_sat;
        end
      end
      PH_DEC, PH_IDLE: hd_chg_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      post_q    <= '0;
      old_q     <= '{default: '0};
      v2c_vld_q <= 1'b0;
      v2c_msg_q <= '0;
      hd_chg_q  <= 1'b0;
    end else begin
      post_q    <= post_d;
      old_q     <= old_d;
      v2c_vld_q <= v2c_vld_d;
      v2c_msg_q <= v2c_msg_d;
      hd_chg_q  <= hd_chg_d;
    end
  end

  assign post    = post_q;
  assign hd      = post_q[A_WID-1];
  assign hd_chg  = hd_chg_q;
  assign v2c_vld = v2c_vld_q;
  assign v2c_msg = v2c_msg_q;

endmodule

`default_nettype wire

// File: tb/tb_ldpc_vn_cell.sv
// tb_ldpc_vn_cell: directed vector table plus hand sequences for reset and
// back-to-back same-edge updates.
`default_nettype none

module tb_ldpc_vn_cell;

  localparam logic [3:0] F_IDLE = 4'b0001;
  localparam logic [3:0] F_LOAD = 4'b0010;
  localparam logic [3:0] F_ITER = 4'b0100;
  localparam logic [3:0] F_DEC  = 4'b1000;

  logic       clk;
  logic       reset_n;
  logic [3:0] fsm;
  logic       sin;
  logic [7:0] din;
  logic       c2v_vld;
  logic [1:0] c2v_idx;
  logic [7:0] c2v_msg;
  logic       v2c_req;
  logic [1:0] v2c_idx;
  logic       v2c_vld;
  logic [7:0] v2c_msg;
  logic       hd;
  logic       hd_chg;
  logic [9:0] post;

  int n_pass = 0;
  int n_tot  = 0;

  ldpc_vn_cell #(.D_WID(8), .A_WID(10), .N_EDGE(3), .E_WID(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fsm     (fsm),
    .sin     (sin),
    .din     (din),
    .c2v_vld (c2v_vld),
    .c2v_idx (c2v_idx),
    .c2v_msg (c2v_msg),
    .v2c_req (v2c_req),
    .v2c_idx (v2c_idx),
    .v2c_vld (v2c_vld),
    .v2c_msg (v2c_msg),
    .hd      (hd),
    .hd_chg  (hd_chg),
    .post    (post)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] fsm;
    logic       sin;
    logic [7:0] din;
    logic       cv;
    logic [1:0] ci;
    logic [7:0] cm;
    logic       vr;
    logic [1:0] vi;
    logic [9:0] e_post;
    logic       e_chg;
    logic       e_vld;
    logic [7:0] e_msg;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(input logic [3:0] f, input logic s, input logic [7:0] d,
                              input logic cv, input logic [1:0] ci, input logic [7:0] cm,
                              input logic vr, input logic [1:0] vi,
                              input logic [9:0] ep, input logic ec, input logic ev,
                              input logic [7:0] em);
    vec_t v;
    v.fsm = f; v.sin = s; v.din = d; v.cv = cv; v.ci = ci; v.cm = cm;
    v.vr = vr; v.vi = vi; v.e_post = ep; v.e_chg = ec; v.e_vld = ev; v.e_msg = em;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic [3:0] f, input logic s, input logic [7:0] d,
                       input logic cv, input logic [1:0] ci, input logic [7:0] cm,
                       input logic vr, input logic [1:0] vi);
    fsm = f; sin = s; din = d; c2v_vld = cv; c2v_idx = ci; c2v_msg = cm;
    v2c_req = vr; v2c_idx = vi;
  endtask

  task automatic chk_all(input string nm, input logic [9:0] ep, input logic ec,
                         input logic ev, input logic [7:0] em);
    chk({nm, ".post"}, 32'(post), 32'(ep));
    chk({nm, ".hd"}, 32'(hd), 32'(ep[9]));
    chk({nm, ".hd_chg"}, 32'(hd_chg), 32'(ec));
    chk({nm, ".v2c_vld"}, 32'(v2c_vld), 32'(ev));
    chk({nm, ".v2c_msg"}, 32'(v2c_msg), 32'(em));
  endtask

  initial begin
    //            fsm     sin din    cv ci  cm     vr vi   post    chg vld msg
    vt[0]  = mk(F_LOAD, 1, 8'hF6, 0, 0, 8'h00, 0, 0, 10'h3F6, 0, 0, 8'h00);
    vt[1]  = mk(F_ITER, 0, 8'h00, 1, 0, 8'h14, 0, 0, 10'h00A, 1, 0, 8'h00);
    vt[2]  = mk(F_ITER, 0, 8'h00, 1, 1, 8'h05, 0, 0, 10'h00F, 1, 0, 8'h00);
    vt[3]  = mk(F_ITER, 0, 8'h00, 0, 0, 8'h00, 1, 0, 10'h00F, 1, 1, 8'hFB);
    vt[4]  = mk(F_ITER, 0, 8'h00, 1, 1, 8'h1E, 1, 1, 10'h028, 1, 1, 8'h0A);
    vt[5]  = mk(F_ITER, 0, 8'h00, 1, 3, 8'h64, 1, 3, 10'h028, 1, 1, 8'h28);
    vt[6]  = mk(F_ITER, 0, 8'h00, 0, 0, 8'h00, 1, 1, 10'h028, 1, 1, 8'h0A);
    vt[7]  = mk(F_ITER, 0, 8'h00, 0, 0, 8'h00, 0, 0, 10'h028, 1, 0, 8'h0A);
    vt[8]  = mk(F_DEC,  0, 8'h00, 1, 0, 8'h32, 1, 0, 10'h028, 0, 0, 8'h0A);
    vt[9]  = mk(F_IDLE, 0, 8'h00, 1, 0, 8'h32, 1, 0, 10'h028, 0, 0, 8'h0A);
    vt[10] = mk(F_LOAD, 1, 8'h7F, 1, 0, 8'h32, 1, 0, 10'h07F, 0, 0, 8'h0A);
    vt[11] = mk(F_ITER, 0, 8'h00, 1, 0, 8'h7F, 0, 0, 10'h0FE, 0, 0, 8'h0A);
    vt[12] = mk(F_ITER, 0, 8'h00, 1, 1, 8'h7F, 1, 2, 10'h17D, 0, 1, 8'h7F);
    vt[13] = mk(F_ITER, 0, 8'h00, 0, 0, 8'h00, 1, 0, 10'h17D, 0, 1, 8'h7F);
    vt[14] = mk(F_LOAD, 1, 8'h80, 0, 0, 8'h00, 0, 0, 10'h380, 0, 0, 8'h7F);
    vt[15] = mk(F_ITER, 0, 8'h00, 1, 0, 8'h80, 0, 0, 10'h300, 0, 0, 8'h7F);
    vt[16] = mk(F_ITER, 0, 8'h00, 1, 1, 8'h80, 0, 0, 10'h280, 0, 0, 8'h7F);
    vt[17] = mk(F_ITER, 0, 8'h00, 1, 2, 8'h80, 0, 0, 10'h201, 0, 0, 8'h7F);
    vt[18] = mk(F_ITER, 0, 8'h00, 0, 0, 8'h00, 1, 2, 10'h201, 0, 1, 8'h81);
    vt[19] = mk(F_ITER, 0, 8'h00, 0, 0, 8'h00, 1, 3, 10'h201, 0, 1, 8'h81);
    vt[20] = mk(F_LOAD, 0, 8'h00, 0, 0, 8'h00, 0, 0, 10'h201, 0, 0, 8'h81);

    reset_n = 1'b0;
    drive(4'b0000, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 10'h000, 0, 0, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vt[i].fsm, vt[i].sin, vt[i].din, vt[i].cv, vt[i].ci, vt[i].cm, vt[i].vr, vt[i].vi);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vt[i].e_post, vt[i].e_chg, vt[i].e_vld, vt[i].e_msg);
    end

    // Build some state, then reset asynchronously between clock edges.
    @(negedge clk);
    drive(F_LOAD, 1, 8'h28, 0, 0, 8'h00, 0, 0);
    @(posedge clk); #1;
    chk_all("rs_load", 10'h028, 0, 0, 8'h81);
    @(negedge clk);
    drive(F_ITER, 0, 8'h00, 1, 0, 8'hCE, 1, 0);
    @(posedge clk); #1;
    chk_all("rs_upd", 10'h3F6, 1, 1, 8'h28);
    drive(F_ITER, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk_all("rs_async", 10'h000, 0, 0, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_all("rs_release", 10'h000, 0, 0, 8'h00);
    @(negedge clk);
    drive(F_ITER, 0, 8'h00, 0, 0, 8'h00, 1, 0);
    @(posedge clk); #1;
    chk_all("rs_old_clr", 10'h000, 0, 1, 8'h00);

    // Back-to-back updates on one edge must see the freshly written old[0].
    @(negedge clk);
    drive(F_ITER, 0, 8'h00, 1, 0, 8'h14, 0, 0);
    @(posedge clk); #1;
    chk_all("b2b_1", 10'h014, 0, 0, 8'h00);
    @(negedge clk);
    drive(F_ITER, 0, 8'h00, 1, 0, 8'h1E, 0, 0);
    @(posedge clk); #1;
    chk_all("b2b_2", 10'h01E, 0, 0, 8'h00);

    @(negedge clk);
    drive(F_IDLE, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
